// File: rtl/logic_issue_ctrl.sv
// Issue sequencer for the 16-bit logic unit: reads operands from an 8-entry register file, drives the unit, writes back the low result half.
// Optional LOGIC_ISSUE_ZFLAG_EN adds a res_zero flag pulsed alongside res_valid.
module logic_issue_ctrl #(
  parameter int DATA_W   = 16,
  parameter int HI_CHECK = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [15:0]           instr,
  input  logic                  ld_en,
  input  logic [2:0]            ld_addr,
  input  logic [DATA_W-1:0]     ld_data,
  output logic [2:0]            alu_opcode,
  output logic [DATA_W-1:0]     alu_in_a,
  output logic [DATA_W-1:0]     alu_in_b,
  input  logic [2*DATA_W-1:0]   alu_result,
  output logic                  res_valid,
  output logic [DATA_W-1:0]     res_data,
  output logic                  res_err,
  input  logic [2:0]            dbg_addr,
  output logic [DATA_W-1:0]     dbg_data
`ifdef LOGIC_ISSUE_ZFLAG_EN
  ,
  output logic                  res_zero
`endif
);

  localparam logic [2:0] OP_ILLEGAL = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WB
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] rf [8];
  logic [2:0]        rd_q;
  logic              illegal_q;
  logic [DATA_W-1:0] hi_q;

  logic [2:0] instr_op, instr_rd, instr_ra, instr_rb;
  logic       accept;
  logic       unused_instr_bits;

  assign instr_op = instr[15:13];
  assign instr_rd = instr[12:10];
  assign instr_ra = instr[9:7];
  assign instr_rb = instr[6:4];
  assign unused_instr_bits = ^instr[3:0];

  // A pending load wins the cycle; the instruction simply waits.
  assign instr_ready = (state == S_IDLE) && !ld_en;
  assign accept      = instr_valid && instr_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WB;
      S_WB:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
      rd_q       <= '0;
      illegal_q  <= 1'b0;
      hi_q       <= '0;
      alu_opcode <= '0;
      alu_in_a   <= '0;
      alu_in_b   <= '0;
      res_data   <= '0;
    end else begin
      if (state == S_IDLE && ld_en) begin
        rf[ld_addr] <= ld_data;
      end
      if (accept) begin
        rd_q      <= instr_rd;
        illegal_q <= (instr_op == OP_ILLEGAL);
        // Illegal ops leave the logic unit inputs exactly as they were.
        if (instr_op != OP_ILLEGAL) begin
          alu_opcode <= instr_op;
          alu_in_a   <= rf[instr_ra];
          alu_in_b   <= rf[instr_rb];
        end
      end
      if (state == S_ISSUE && !illegal_q) begin
        res_data <= alu_result[DATA_W-1:0];
        hi_q     <= alu_result[2*DATA_W-1:DATA_W];
      end
      if (state == S_WB && !illegal_q) begin
        rf[rd_q] <= res_data;
      end
    end
  end

  assign res_valid = (state == S_WB) && !illegal_q;
  assign res_err   = (state == S_WB) &&
                     (illegal_q || ((HI_CHECK != 0) && (hi_q != '0)));
  assign dbg_data  = rf[dbg_addr];

`ifdef LOGIC_ISSUE_ZFLAG_EN
  assign res_zero = res_valid && (res_data == '0);
`endif

endmodule

// File: tb/tb_logic_issue_ctrl.sv
// Directed bench for logic_issue_ctrl; the bench plays the logic unit (000 AND, 001 OR, 110 XOR).
module tb_logic_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [15:0] ld_data;
  logic [2:0]  alu_opcode;
  logic [15:0] alu_in_a;
  logic [15:0] alu_in_b;
  logic [31:0] alu_result;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_err;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;
`ifdef LOGIC_ISSUE_ZFLAG_EN
  logic        res_zero;
`endif

  logic [15:0] hi_force;
  logic [15:0] alu_lo;
  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  logic_issue_ctrl #(.DATA_W(16), .HI_CHECK(1)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_opcode(alu_opcode), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
    .alu_result(alu_result),
    .res_valid(res_valid), .res_data(res_data), .res_err(res_err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`ifdef LOGIC_ISSUE_ZFLAG_EN
    , .res_zero(res_zero)
`endif
  );

  always_comb begin
    alu_lo = alu_in_a;
    case (alu_opcode)
      3'b000: alu_lo = alu_in_a & alu_in_b;
      3'b001: alu_lo = alu_in_a | alu_in_b;
      3'b110: alu_lo = alu_in_a ^ alu_in_b;
      default: alu_lo = alu_in_a;
    endcase
  end
  assign alu_result = {hi_force, alu_lo};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic dbg_chk(input string tag, input logic [2:0] a, input logic [15:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, {16'h0, dbg_data}, {16'h0, exp});
  endtask

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                     input logic [2:0] ra, input logic [2:0] rb);
    return {op, rd, ra, rb, 4'h0};
  endfunction

  task automatic load(input logic [2:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  // Present an instruction for one accept edge; returns during the ISSUE cycle.
  task automatic issue(input logic [15:0] ins);
    instr_valid = 1'b1; instr = ins;
    tick();
    instr_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = '0; ld_en = 1'b0; ld_addr = '0;
    ld_data = '0; dbg_addr = '0; hi_force = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_ready", {31'h0, instr_ready}, 32'h1);
    chk("rst_valid", {31'h0, res_valid}, 32'h0);
    chk("rst_err", {31'h0, res_err}, 32'h0);
    chk("rst_opcode", {29'h0, alu_opcode}, 32'h0);
    chk("rst_a", {16'h0, alu_in_a}, 32'h0);
    chk("rst_b", {16'h0, alu_in_b}, 32'h0);
    chk("rst_res", {16'h0, res_data}, 32'h0);
    for (int i = 0; i < 8; i++) dbg_chk("rst_rf", 3'(i), 16'h0);

    // AND r3 = r1 & r2
    load(3'd1, 16'hF0F0);
    load(3'd2, 16'h0FF0);
    issue(mk(3'b000, 3'd3, 3'd1, 3'd2));
    chk("and_opcode", {29'h0, alu_opcode}, 32'h0);
    chk("and_a", {16'h0, alu_in_a}, 32'h0000F0F0);
    chk("and_b", {16'h0, alu_in_b}, 32'h00000FF0);
    chk("and_issue_valid", {31'h0, res_valid}, 32'h0);
    chk("and_issue_ready", {31'h0, instr_ready}, 32'h0);
    tick();
    chk("and_wb_valid", {31'h0, res_valid}, 32'h1);
    chk("and_wb_data", {16'h0, res_data}, 32'h000000F0);
    chk("and_wb_err", {31'h0, res_err}, 32'h0);
`ifdef LOGIC_ISSUE_ZFLAG_EN
    chk("and_zero", {31'h0, res_zero}, 32'h0);
`endif
    tick();
    chk("and_idle_valid", {31'h0, res_valid}, 32'h0);
    chk("and_idle_ready", {31'h0, instr_ready}, 32'h1);
    dbg_chk("and_r3", 3'd3, 16'h00F0);

    // Back-to-back: OR then XOR with instr_valid held high
    instr_valid = 1'b1; instr = mk(3'b001, 3'd4, 3'd1, 3'd2);
    tick();
    instr = mk(3'b110, 3'd5, 3'd1, 3'd2);
    chk("b2b_ready_c1", {31'h0, instr_ready}, 32'h0);
    tick();
    chk("b2b_ready_c2", {31'h0, instr_ready}, 32'h0);
    chk("b2b_or_valid", {31'h0, res_valid}, 32'h1);
    chk("b2b_or_data", {16'h0, res_data}, 32'h0000FFF0);
    tick();
    chk("b2b_ready_c3", {31'h0, instr_ready}, 32'h1);
    tick();
    instr_valid = 1'b0;
    chk("b2b_xor_opcode", {29'h0, alu_opcode}, 32'h6);
    tick();
    chk("b2b_xor_valid", {31'h0, res_valid}, 32'h1);
    chk("b2b_xor_data", {16'h0, res_data}, 32'h0000FF00);
    tick();
    dbg_chk("b2b_r4", 3'd4, 16'hFFF0);
    dbg_chk("b2b_r5", 3'd5, 16'hFF00);

    // Load and instruction in the same IDLE cycle: load wins
    instr_valid = 1'b1; instr = mk(3'b000, 3'd6, 3'd1, 3'd7);
    ld_en = 1'b1; ld_addr = 3'd7; ld_data = 16'hFFFF;
    #1;
    chk("ld_pri_ready", {31'h0, instr_ready}, 32'h0);
    tick();
    ld_en = 1'b0;
    #1;
    chk("ld_after_ready", {31'h0, instr_ready}, 32'h1);
    tick();
    instr_valid = 1'b0;
    chk("ld_new_b", {16'h0, alu_in_b}, 32'h0000FFFF);
    tick();
    chk("ld_wb_data", {16'h0, res_data}, 32'h0000F0F0);
    tick();

    // Illegal op: alu_* unchanged, no writeback, error pulse
    issue(mk(3'b011, 3'd1, 3'd2, 3'd2));
    chk("ill_opcode", {29'h0, alu_opcode}, 32'h0);
    chk("ill_a", {16'h0, alu_in_a}, 32'h0000F0F0);
    chk("ill_b", {16'h0, alu_in_b}, 32'h0000FFFF);
    tick();
    chk("ill_err", {31'h0, res_err}, 32'h1);
    chk("ill_valid", {31'h0, res_valid}, 32'h0);
`ifdef LOGIC_ISSUE_ZFLAG_EN
    chk("ill_zero", {31'h0, res_zero}, 32'h0);
`endif
    tick();
    chk("ill_err_end", {31'h0, res_err}, 32'h0);
    chk("ill_res_hold", {16'h0, res_data}, 32'h0000F0F0);
    dbg_chk("ill_r1", 3'd1, 16'hF0F0);
    dbg_chk("ill_r2", 3'd2, 16'h0FF0);

    // Nonzero upper half on a legal op
    hi_force = 16'h0001;
    issue(mk(3'b001, 3'd0, 3'd1, 3'd2));
    tick();
    chk("hi_err", {31'h0, res_err}, 32'h1);
    chk("hi_valid", {31'h0, res_valid}, 32'h1);
    chk("hi_data", {16'h0, res_data}, 32'h0000FFF0);
    hi_force = 16'h0000;
    tick();
    chk("hi_err_end", {31'h0, res_err}, 32'h0);
    dbg_chk("hi_r0", 3'd0, 16'hFFF0);

    // Reset during ISSUE aborts the instruction
    issue(mk(3'b110, 3'd2, 3'd1, 3'd1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", {31'h0, instr_ready}, 32'h1);
    chk("mid_rst_opcode", {29'h0, alu_opcode}, 32'h0);
    chk("mid_rst_a", {16'h0, alu_in_a}, 32'h0);
    chk("mid_rst_res", {16'h0, res_data}, 32'h0);
    chk("mid_rst_valid", {31'h0, res_valid}, 32'h0);
    dbg_chk("mid_rst_r1", 3'd1, 16'h0);
    dbg_chk("mid_rst_r5", 3'd5, 16'h0);
    tick();
    chk("mid_rst_no_pulse", {31'h0, res_valid | res_err}, 32'h0);
    dbg_chk("mid_rst_r2", 3'd2, 16'h0);

`ifdef LOGIC_ISSUE_ZFLAG_EN
    load(3'd1, 16'h1234);
    issue(mk(3'b110, 3'd3, 3'd1, 3'd1));
    tick();
    chk("z_data", {16'h0, res_data}, 32'h0);
    chk("z_flag", {31'h0, res_zero}, 32'h1);
    tick();
    chk("z_flag_end", {31'h0, res_zero}, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/logic_issue_ctrl.md
Name: logic_issue_ctrl

Overview:
- Sequencer that sits on the operand/opcode side of the 16-bit logic unit; the logic unit itself is a separate block.
- Accepts 16-bit register-to-register logic instructions over a valid/ready handshake.
- Reads operands from an internal 8x16 register file, drives opcode and operands to the logic unit, and captures its 32-bit result.
- Writes the low half back to the register file and reports completion.

Parameters:
- DATA_W, 16, operand/register width. The result bus is 2*DATA_W.
- HI_CHECK, 1, when 1 a nonzero upper result half raises res_err.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  instruction accepted when instr_valid && instr_ready
- instr  in  16  instruction: [15:13] op, [12:10] rd, [9:7] ra, [6:4] rb, [3:0] ignored
- ld_en  in  1  external register load request
- ld_addr  in  3  load target register
- ld_data  in  DATA_W  load value
- alu_opcode  out  3  to logic unit opcode
- alu_in_a  out  DATA_W  to logic unit operand a
- alu_in_b  out  DATA_W  to logic unit operand b
- alu_result  in  2*DATA_W  from logic unit, combinational
- res_valid  out  1  one-cycle completion pulse
- res_data  out  DATA_W  value written back, valid with res_valid
- res_err  out  1  one-cycle pulse: illegal op or nonzero upper half
- dbg_addr  in  3  debug read address
- dbg_data  out  DATA_W  combinational read of rf[dbg_addr]

Behaviour:
- Reset: all 8 registers = 0, state IDLE, alu_opcode/alu_in_a/alu_in_b = 0, res_valid = 0, res_data = 0, res_err = 0. Reset mid-operation aborts the instruction with no writeback and no pulse.
- States: IDLE, ISSUE, WB.
- instr_ready = (state==IDLE) && !ld_en. Combinational; does not depend on instr_valid.
- Load port:
  - ld_en in IDLE writes rf[ld_addr] = ld_data at the edge.
  - ld_en outside IDLE is ignored (dropped, no stall).
  - Load has priority over instruction acceptance in the same cycle.
- Accept edge (IDLE, handshake true):
  - Latch rd.
  - alu_opcode <= op, alu_in_a <= rf[ra], alu_in_b <= rf[rb]. The register-file read uses contents before this edge.
  - Go to ISSUE.
- Illegal op 3'b011:
  - Accepted normally, but alu_* outputs are left unchanged and the register file is untouched.
  - Next cycle res_err = 1, res_valid = 0; state goes to WB and then IDLE (same 3-cycle occupancy).
- ISSUE: alu_* are stable for this whole cycle. At its end, res_data <= alu_result[DATA_W-1:0] and the upper half is captured for checking. Go to WB.
- WB, for one cycle:
  - rf[rd] = res_data, committed at the end of WB.
  - res_valid = 1, res_data valid.
  - res_err = 1 if HI_CHECK and the captured upper half != 0.
  - Go to IDLE.
- Latency: accept at edge N, res_valid high in cycle N+2, instr_ready high again in cycle N+3. Maximum throughput is 1 instruction per 3 cycles.
- Hazards: instruction occupancy is serialized, so no forwarding is needed. rd==ra==rb is legal; the old values are read.
- res_valid and res_err are single-cycle pulses; res_data holds its value until the next WB.
- dbg_data reflects the committed register file (a write becomes visible the cycle after its edge).
- alu_* hold their last values in IDLE.

Optional Feature:
- Macro LOGIC_ISSUE_ZFLAG_EN.
- When defined: an extra output port res_zero (1 bit), pulsed with res_valid, = 1 iff the written-back res_data == 0. Its reset value is 0. Illegal ops keep it 0.
- When undefined: the port does not exist and the behaviour is otherwise identical.

Test Plan:
- Reset, then load r1=16'hF0F0 and r2=16'h0FF0; issue op 000 rd=3 ra=1 rb=2 -> alu_opcode=000 in ISSUE; res_valid 2 cycles after accept with res_data=16'h00F0; dbg r3=16'h00F0; res_err=0.
- Back-to-back instr_valid held high with ops 001 and 110 on r1,r2 -> instr_ready low for 2 cycles between accepts; results 16'hFFF0 then 16'hFF00 in order.
- ld_en and instr_valid both high in IDLE -> instr_ready=0, load commits; instruction accepted the next cycle using the new value.
- Op 011 -> res_err pulse, res_valid=0, all registers unchanged, alu_* unchanged; force alu_result upper half = 16'h0001 on a legal op -> res_err=1 with res_valid=1.
- Assert rst during ISSUE -> no writeback, all outputs and registers return to 0, instr_ready=1 the cycle after rst drops.
- With LOGIC_ISSUE_ZFLAG_EN: op 110 with ra==rb -> res_data=0, res_zero=1.
